// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : spi_pkg                                                      |
// | Description : Shared types and constants for the SPI word controller:     |
// |               FSM state encoding, default timing constants, SPI mode and   |
// |               a helper that sizes the phase counter.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spi_pkg;

  // Transaction FSM states. HIGH/LOW are the two SCK half-periods of a bit;
  // GAP replaces LOW after the last bit of every non-final byte.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    GAP   = 3'd4,
    TRAIL = 3'd5,
    GUARD = 3'd6
  } spi_state_t;

  // Default timing: clk cycles per SCK half-period and extra inter-byte gap.
  localparam int c_default_clk_div  = 4;
  localparam int c_default_byte_gap = 8;

  // SPI mode 0: SCK idles low, data sampled on the rising SCK edge.
  localparam bit c_spi_cpol = 1'b0;
  localparam bit c_spi_cpha = 1'b0;

  // Phase counter must hold the longest reload value (gap + half-period - 1).
  function automatic int phase_count_width(input int half, input int gap);
    int span;
    span = (gap + half > half) ? gap + half : half;
    return (span > 2) ? $clog2(span) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_phase_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_phase_counter                                            |
// | Description : Loadable down-counter. Reloaded by the FSM at the start of   |
// |               every SCK phase; expire is high while the count is zero,     |
// |               i.e. during the last clk cycle of the phase.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports:                                                                     |
// |   clk        in   system clock                                            |
// |   resetn     in   asynchronous active-low reset                           |
// |   load       in   reload the counter with load_value                      |
// |   load_value in   phase length minus one                                  |
// |   expire     out  high during the final cycle of the phase                 |
// +----------------------------------------------------------------------------+
module spi_phase_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expire = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/spi_word_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_word_controller                                          |
// | Description : Mode-0 SPI controller exchanging one BITS-wide word per      |
// |               transaction. Bytes go out little-endian, MSB-first within    |
// |               each byte; received bytes are assembled the same way.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports:                                                                     |
// |   clk                 in   system clock                                   |
// |   resetn              in   asynchronous active-low reset                  |
// |   start               in   transfer request, accepted only when idle      |
// |   word_send_data      in   word to send, captured on accept               |
// |   busy                out  transaction in progress (incl. CS guard)       |
// |   done                out  one-cycle pulse, received word valid           |
// |   word_data_received  out  last received word                            |
// |   SCK / CS / COPI     out  SPI clock, chip select (active low), data out   |
// |   CIPO                in   SPI data in                                    |
// +----------------------------------------------------------------------------+
module spi_word_controller
  import spi_pkg::*;
#(
  parameter int BITS     = 64,
  parameter int CLK_DIV  = c_default_clk_div,
  parameter int BYTE_GAP = c_default_byte_gap
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [BITS-1:0] word_send_data,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] word_data_received,
  output logic            SCK,
  output logic            CS,
  output logic            COPI,
  input  logic            CIPO
);

  localparam int c_nbytes = BITS / 8;
  localparam int c_bcw    = (c_nbytes > 1) ? $clog2(c_nbytes) : 1;
  localparam int c_pw     = phase_count_width(CLK_DIV, BYTE_GAP);

  localparam logic [c_pw-1:0]  c_half_load = c_pw'(CLK_DIV - 1);
  localparam logic [c_pw-1:0]  c_gap_load  = c_pw'(BYTE_GAP + CLK_DIV - 1);
  localparam logic [c_bcw-1:0] c_last_byte = c_bcw'(c_nbytes - 1);

  spi_state_t r_state;
  spi_state_t w_state_next;

  logic            w_load;
  logic [c_pw-1:0] w_load_value;
  logic            w_expire;

  // Single-cycle control events decoded by the FSM for the datapath.
  logic w_accept;
  logic w_rise;
  logic w_fall;
  logic w_finish;
  logic w_release;

  logic [2:0]       r_bit_cnt;
  logic [c_bcw-1:0] r_byte_cnt;
  logic [BITS-1:0]  r_tx;
  logic [6:0]       r_rx;
  logic [7:0]       w_rx_byte;
  logic [BITS-1:0]  r_rx_word;
  logic [BITS-1:0]  r_word_out;
  logic             w_last_bit;
  logic             w_last_byte;
  logic             w_next_msb;

  logic r_sck;
  logic r_cs;
  logic r_copi;
  logic r_busy;
  logic r_done;

  assign w_last_bit  = (r_bit_cnt == 3'd7);
  assign w_last_byte = (r_byte_cnt == c_last_byte);
  assign w_rx_byte   = {r_rx, CIPO};

  // MSB of the following byte; a single-byte word never has one.
  if (c_nbytes > 1) begin : g_multi_byte
    assign w_next_msb = r_tx[15];
  end else begin : g_single_byte
    assign w_next_msb = 1'b0;
  end

  spi_phase_counter #(
    .WIDTH(c_pw)
  ) u_phase (
    .clk       (clk),
    .resetn    (resetn),
    .load      (w_load),
    .load_value(w_load_value),
    .expire    (w_expire)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_value = c_half_load;
    w_accept     = 1'b0;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    w_finish     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_load       = 1'b1;
          w_state_next = LEAD;
        end
      end
      LEAD, LOW, GAP: begin
        if (w_expire) begin
          w_rise       = 1'b1;
          w_load       = 1'b1;
          w_state_next = HIGH;
        end
      end
      HIGH: begin
        if (w_expire) begin
          w_fall = 1'b1;
          w_load = 1'b1;
          if (!w_last_bit) begin
            w_state_next = LOW;
          end else if (w_last_byte) begin
            w_state_next = TRAIL;
          end else begin
            w_load_value = c_gap_load;
            w_state_next = GAP;
          end
        end
      end
      TRAIL: begin
        if (w_expire) begin
          w_finish     = 1'b1;
          w_load       = 1'b1;
          w_state_next = GUARD;
        end
      end
      GUARD: begin
        if (w_expire) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sck      <= c_spi_cpol;
      r_cs       <= 1'b1;
      r_copi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_word  <= '0;
      r_word_out <= '0;
    end else begin
      r_done <= w_finish;

      if (w_accept) begin
        r_tx       <= word_send_data;
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        r_cs       <= 1'b0;
        r_busy     <= 1'b1;
        r_copi     <= word_send_data[7];
      end

      if (w_rise) begin
        r_sck <= 1'b1;
        r_rx  <= w_rx_byte[6:0];
        if (w_last_bit) begin
          for (int k = 0; k < c_nbytes; k++) begin
            if (r_byte_cnt == c_bcw'(k)) begin
              r_rx_word[8*k +: 8] <= w_rx_byte;
            end
          end
        end
      end

      // Bit counter wraps 7 -> 0 on its own at the end of each byte.
      if (w_fall) begin
        r_sck     <= 1'b0;
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (!w_last_bit) begin
          r_copi    <= r_tx[6];
          r_tx[7:0] <= {r_tx[6:0], 1'b0};
        end else if (w_last_byte) begin
          r_copi <= 1'b0;
        end else begin
          r_copi     <= w_next_msb;
          r_tx       <= r_tx >> 8;
          r_byte_cnt <= r_byte_cnt + 1'b1;
        end
      end

      if (w_finish) begin
        r_cs       <= 1'b1;
        r_word_out <= r_rx_word;
      end

      if (w_release) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign SCK                = r_sck;
  assign CS                 = r_cs;
  assign COPI               = r_copi;
  assign busy               = r_busy;
  assign done               = r_done;
  assign word_data_received = r_word_out;

endmodule
`default_nettype wire
